// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: time-multiplexed LED matrix driver.
// Scans a ROWS x COLS image one column at a time. Each column dwells for
// SCAN_DIV cycles: BLANK_CYCLES with everything off to suppress ghosting,
// then PWM-modulated drive. Frames arrive via a valid/ready handshake into
// a pending buffer and are promoted to the display buffer only on a frame
// boundary, or immediately while idle.
module led_matrix_scanner #(
  parameter int ROWS         = 5,
  parameter int COLS         = 5,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int PWM_BITS     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [ROWS*COLS-1:0]  cells,
  input  logic                  cells_valid,
  output logic                  cells_ready,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [ROWS-1:0]       rows,
  output logic [COLS-1:0]       cols,
  output logic [$clog2(COLS):0] col_index,
  output logic                  frame_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(COLS) + 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]   DWELL_DRV  = DW'(BLANK_CYCLES);
  localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
  localparam logic [COLS-1:0] COL_ONE    = COLS'(1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                 state;
  logic [DW-1:0]          dwell;
  logic [PWM_BITS-1:0]    pwm_cnt;
  logic [PWM_BITS-1:0]    bright_q;
  logic [ROWS*COLS-1:0]   display;
  logic [ROWS*COLS-1:0]   pending;
  logic                   pending_full;

  logic [DW-1:0]          dwell_inc;
  logic [PWM_BITS-1:0]    pwm_inc;
  logic [CW-1:0]          col_inc;
  logic                   at_last;
  logic                   at_boundary;
  logic                   pwm_on;
  logic                   swap;
  logic [COLS-1:0]        col_sel;
  logic [ROWS-1:0]        drive_rows;

  assign dwell_inc   = dwell + DW'(1);
  // pwm restarts at 0 on the first DRIVE cycle of every column
  assign pwm_inc     = (state == DRIVE) ? pwm_cnt + PWM_BITS'(1) : '0;
  assign col_inc     = (col_index == COL_LAST) ? '0 : col_index + CW'(1);
  assign at_last     = (state != IDLE) && (dwell == DWELL_LAST);
  assign at_boundary = at_last && (col_index == COL_LAST);
  assign col_sel     = COL_ONE << col_index;
  assign pwm_on      = (pwm_inc <= bright_q);
  assign swap        = pending_full && ((state == IDLE) || at_boundary);
  assign cells_ready = ~pending_full;

  // Row drive for the next DRIVE cycle: one-hot column mask picks the cell
  // out of each row slice, which avoids a variable bit index per row.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign drive_rows[r] = ~(pwm_on & (|(display[r*COLS +: COLS] & col_sel)));
  end

  // Scan FSM; outputs are registered from the state chosen at each edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dwell      <= '0;
      col_index  <= '0;
      pwm_cnt    <= '0;
      bright_q   <= '0;
      rows       <= '1;
      cols       <= '0;
      frame_done <= 1'b0;
    end else if (!ena) begin
      // drop out mid-column; the partial frame is discarded
      state      <= IDLE;
      dwell      <= '0;
      col_index  <= '0;
      pwm_cnt    <= '0;
      rows       <= '1;
      cols       <= '0;
      frame_done <= 1'b0;
    end else if (state == IDLE || at_last) begin
      // start of a column: blank, sample brightness for the whole column
      state      <= BLANK;
      dwell      <= '0;
      pwm_cnt    <= '0;
      bright_q   <= brightness;
      col_index  <= (state == IDLE) ? '0 : col_inc;
      rows       <= '1;
      cols       <= '0;
      frame_done <= 1'b0;
    end else if (dwell_inc < DWELL_DRV) begin
      state      <= BLANK;
      dwell      <= dwell_inc;
      rows       <= '1;
      cols       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= DRIVE;
      dwell      <= dwell_inc;
      pwm_cnt    <= pwm_inc;
      rows       <= drive_rows;
      cols       <= col_sel;
      frame_done <= (dwell_inc == DWELL_LAST) && (col_index == COL_LAST);
    end
  end

  // Double buffer: swap and accept are exclusive because ready = ~pending_full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      display      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (swap) begin
      display      <= pending;
      pending_full <= 1'b0;
    end else if (cells_valid && !pending_full) begin
      pending      <= cells;
      pending_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: directed phases plus random traffic, with a
// time-based reference model (column/dwell/pwm derived from cycles since
// scan start) checked every cycle.
module tb_led_matrix_scanner;
  localparam int ROWS = 3, COLS = 4, SD = 8, BL = 2, PB = 2;
  localparam int FR = COLS * SD;
  localparam int NC = ROWS * COLS;

  logic clk = 1'b0, rst = 1'b0, ena = 1'b0, cells_valid = 1'b0;
  logic [NC-1:0] cells = '0;
  logic [PB-1:0] brightness = '0;
  logic cells_ready, frame_done;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic [$clog2(COLS):0] col_index;

  int n_chk = 0, n_fail = 0;

  // reference model
  bit m_run, m_full, m_acc;
  int m_t, m_bq;
  logic [NC-1:0] m_disp, m_pend;
  logic [NC-1:0] q[$];

  always #5 clk = ~clk;

  led_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD),
                       .BLANK_CYCLES(BL), .PWM_BITS(PB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cells(cells), .cells_valid(cells_valid),
    .cells_ready(cells_ready), .brightness(brightness), .rows(rows), .cols(cols),
    .col_index(col_index), .frame_done(frame_done));

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_disp = '0; m_full = 0; m_bq = 0;
  endtask

  // Apply the effect of one rising edge using the inputs it samples.
  task automatic model_step();
    bit bnd;
    m_acc = 0;
    if (!rst) begin model_reset(); return; end
    bnd = m_run && (m_t % FR == FR - 1);
    if (m_full && (!m_run || bnd)) begin
      m_disp = m_pend; m_full = 0;
    end else if (cells_valid && !m_full) begin
      m_pend = cells; m_full = 1; m_acc = 1;
    end
    if (!ena) m_run = 0;
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
    if (m_run && (m_t % SD == 0)) m_bq = int'(brightness);
  endtask

  task automatic check_outs(string tag);
    logic [ROWS-1:0] er = '1;
    logic [COLS-1:0] ec = '0;
    int ei = 0;
    bit ef = 0;
    if (m_run) begin
      int c = (m_t / SD) % COLS;
      int d = m_t % SD;
      ei = c;
      ef = ((m_t % FR) == FR - 1);
      if (d >= BL) begin
        ec[c] = 1'b1;
        for (int r = 0; r < ROWS; r++)
          er[r] = !(m_disp[r*COLS+c] && (((d - BL) % (1 << PB)) <= m_bq));
      end
    end
    chk($sformatf("%s.rows", tag), 32'(rows), 32'(er));
    chk($sformatf("%s.cols", tag), 32'(cols), 32'(ec));
    chk($sformatf("%s.col_index", tag), 32'(col_index), 32'(ei));
    chk($sformatf("%s.frame_done", tag), 32'(frame_done), 32'(ef));
    chk($sformatf("%s.cells_ready", tag), 32'(cells_ready), 32'(!m_full));
  endtask

  task automatic offer();
    cells_valid = (q.size() != 0);
    if (q.size() != 0) cells = q[0];
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk); #1;
    check_outs(tag);
    if (m_acc) void'(q.pop_front());
    offer();
  endtask

  initial begin
    int fd_cnt;
    bit found;
    model_reset();

    // reset state, then release with ena=0
    repeat (3) tick("reset");
    rst = 1'b1;
    repeat (3) tick("post_reset");

    // pattern: load while idle, then scan two frames at full brightness
    q.push_back(12'hA5C); offer();
    repeat (3) tick("load");
    brightness = 2'd3; ena = 1'b1;
    fd_cnt = 0;
    repeat (2 * FR) begin
      tick("pattern");
      if (frame_done === 1'b1) fd_cnt++;
    end
    chk("frame_done_count", 32'(fd_cnt), 32'd2);

    // back-pressure: two frames offered back to back mid-frame
    repeat (5) tick("bp_pre");
    q.push_back(NC'($urandom)); q.push_back(NC'($urandom)); offer();
    repeat (3 * FR) tick("backpressure");

    // pwm with all cells lit, then brightness wiggled mid-column
    q.push_back('1); offer();
    brightness = 2'd1;
    repeat (2 * FR) tick("pwm");
    for (int i = 0; i < 2 * FR; i++) begin
      if ($urandom_range(0, 5) == 0) brightness = PB'($urandom);
      tick("pwm_change");
    end

    // enable drop during column 2, then restart
    found = 0;
    for (int i = 0; i < 4 * FR && !found; i++) begin
      tick("seek_col2");
      if (m_run && ((m_t / SD) % COLS == 2) && (m_t % SD == 4)) found = 1;
    end
    chk("seek_col2", 32'(found), 32'd1);
    ena = 1'b0;
    repeat (3) tick("ena_drop");
    ena = 1'b1;
    repeat (2 * SD) tick("ena_restart");

    // idle swap
    ena = 1'b0;
    repeat (2) tick("idle");
    q.push_back(NC'($urandom)); offer();
    repeat (4) tick("idle_swap");
    ena = 1'b1;
    repeat (FR) tick("idle_show");

    // async reset mid-DRIVE with a frame pending
    q.push_back(NC'($urandom)); offer();
    found = 0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      tick("seek_drive");
      if (m_run && (m_t % SD == BL + 2)) found = 1;
    end
    chk("seek_drive", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.rows", 32'(rows), 32'h7);
    chk("async_rst.cols", 32'(cols), 32'h0);
    chk("async_rst.cells_ready", 32'(cells_ready), 32'h1);
    chk("async_rst.frame_done", 32'(frame_done), 32'h0);
    model_reset();
    ena = 1'b0;
    @(posedge clk); #1;
    repeat (2) tick("in_reset");
    rst = 1'b1;
    repeat (3) tick("after_reset");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      ena = ($urandom_range(0, 999) < 995);
      if ($urandom_range(0, 99) < 4) begin q.push_back(NC'($urandom)); offer(); end
      if ($urandom_range(0, 9) == 0) brightness = PB'($urandom);
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Time-multiplexed, clocked LED matrix driver that replaces the combinational single-column driver. It scans a ROWS x COLS cell image one column at a time with a programmable dwell, blanks between columns to suppress ghosting, and applies PWM brightness. A valid/ready handshake accepts new frames, which are double-buffered so the display changes only on frame boundaries. It sits between the Conway game-of-life core (frame source) and the LED matrix pins.

## Interface
Parameters:
- ROWS, 5, matrix rows (1..16)
- COLS, 5, matrix columns (1..16); non-square allowed
- SCAN_DIV, 1000, clock cycles per column dwell; must be > BLANK_CYCLES
- BLANK_CYCLES, 2, blanked cycles at the start of each dwell (>= 1)
- PWM_BITS, 3, brightness resolution (1..8)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- ena  in  1  display enable; synchronous
- cells  in  ROWS*COLS  frame image; cell (r,c) at bit r*COLS+c; 1 = lit
- cells_valid  in  1  frame offered
- cells_ready  out  1  frame accepted when valid&ready at a rising edge
- brightness  in  PWM_BITS  duty code
- rows  out  ROWS  row drive, active-low (0 = lit cell in the driven column)
- cols  out  COLS  column drive, one-hot active-high, or all-zero when blanked
- col_index  out  $clog2(COLS)+1  column currently scanned
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- Storage: pending buffer (ROWS*COLS bits + pending_full flag) and display buffer (ROWS*COLS bits).
- cells_ready = ~pending_full (combinational from the register). Accept: load pending, set pending_full.
- Swap: display <= pending and pending_full <= 0 at the frame boundary edge (last cycle of column COLS-1) or on any edge in IDLE, only when pending_full=1. A frame accepted on the boundary edge itself was not pending before that edge; it stays pending until the next boundary.
- States: IDLE, BLANK, DRIVE.
  - IDLE: ena=0. Counters held at 0, col_index=0, outputs blanked.
  - IDLE -> BLANK when ena=1, starting column 0, dwell=0.
  - BLANK: dwell < BLANK_CYCLES. cols=0, rows all-1.
  - DRIVE: BLANK_CYCLES <= dwell < SCAN_DIV. cols=one-hot(col_index).
  - rows[r] = ~(display[r*COLS+col_index] & (pwm_cnt <= bright_q)).
  - At dwell=SCAN_DIV-1: dwell <= 0, next column, state BLANK. col_index wraps COLS-1 -> 0; that cycle is the frame boundary.
  - Any state -> IDLE on the edge sampling ena=0, including mid-column. Partial frame discarded; no frame_done.
- PWM: pwm_cnt is PWM_BITS wide, 0 on entry to DRIVE, +1 per DRIVE cycle, wraps naturally.
  - bright_q samples brightness on entry to BLANK of each column; changes mid-column are ignored.
  - Duty = (bright_q+1)/2^PWM_BITS. All-ones = continuously on; 0 = 1 cycle in 2^PWM_BITS.
- frame_done=1 for exactly the boundary cycle. No effect on handshake beyond the swap.

## Timing
- Reset (rst=0, async): state IDLE, dwell=0, pwm_cnt=0, col_index=0, bright_q=0, display=0, pending_full=0.
  - Outputs: rows all-1, cols=0, frame_done=0, cells_ready=1 (pending_full=0).
  - Release is synchronous to the next rising edge.
- rows/cols/col_index/frame_done are registered: the cycle after an edge reflects state decided at that edge.
- Scan start: first BLANK output cycle is the cycle after the edge that samples ena=1 in IDLE.
- Each column: exactly SCAN_DIV output cycles = BLANK_CYCLES blanked + (SCAN_DIV-BLANK_CYCLES) driven.
- Frame period = COLS*SCAN_DIV cycles.
- Swap latency: a frame accepted at any edge of frame k is displayed from the first column of frame k+1. Accepted on frame k's boundary edge -> displayed from frame k+2.
- Simultaneous accept and boundary with pending_full=1: impossible, since ready=0.
- cols is never non-zero for two different columns in the same or adjacent cycles; at least BLANK_CYCLES of all-zero cols separate columns.

## Test plan
- Reset: assert rst=0 mid-DRIVE -> same cycle rows=all-1, cols=0, cells_ready=1, frame_done=0; after release with ena=0, outputs stay blanked.
- Pattern (ROWS=3, COLS=4, SCAN_DIV=8, BLANK_CYCLES=2, PWM_BITS=2, brightness=3): load cells=12'hA5C, ena=1.
  - Per column: 2 cycles cols=0, then 6 cycles cols=0001/0010/0100/1000.
  - rows = ~{cell(2,c),cell(1,c),cell(0,c)}; frame_done every 32 cycles.
- Back-pressure: offer frames F1, F2 back-to-back.
  - F1 accepted, then ready=0 until the next boundary; F2 accepted the cycle after the swap.
  - Display shows F1 for one full frame, then F2.
- PWM (brightness=1, PWM_BITS=2, all cells lit): each 6-cycle drive shows rows=000,000,111,111,000,000.
  - brightness changed mid-column takes effect next column only.
- Enable drop: ena=0 during column 2 -> next output cycle blanked, col_index=0, no frame_done.
  - ena=1 again -> scan restarts at column 0 with BLANK.
- Idle swap: ena=0, offer frame -> accepted; pending_full clears next edge; ready returns to 1; frame shown on first column after ena=1.
